// File: rtl/mic_sample_scheduler.sv
// -----------------------------------------------------------------------------
// mic_sample_scheduler
//
// Purpose:
//   Sample-rate controller for the tracking microphone array. A free-running
//   divider produces a one-cycle tick every SAMPLE_DIV clocks while sampling is
//   enabled. On each accepted tick every PmodMIC serial interface is started at
//   the same moment, so the channel samples are time-aligned for localization.
//   The scheduler waits for the slowest channel, latches all results into a
//   single frame and pulses o_frame_valid.
//
// Optional feature (compile-time macro MIC_TIMEOUT_EN):
//   When defined, each handshake phase (START, CONVERT) is bounded by
//   TIMEOUT_CYCLES clocks. On expiry the frame is abandoned, start requests are
//   dropped, o_timeout_err is set (sticky until reset) and the FSM returns to
//   WAIT_TICK without producing a frame. When undefined the FSM waits
//   indefinitely and o_timeout_err is tied low.
//
// Ports:
//   i_clock        system clock
//   i_reset        asynchronous reset, active low (asserted when 0)
//   i_enable       sampling enable
//   i_mic_done     per-channel done level from the mic interfaces (1 = idle)
//   i_mic_data     per-channel result, channel i at [i*DATA_W +: DATA_W]
//   o_mic_start    per-channel start request (level, held until acknowledged)
//   o_samples      latched frame, same packing as i_mic_data
//   o_frame_valid  one-cycle pulse in the first cycle o_samples holds a frame
//   o_frame_count  number of frames captured (wraps at 16 bits)
//   o_overrun      sticky: a tick arrived while a frame was in progress
//   o_busy         high in START, CONVERT and CAPTURE
//   o_timeout_err  sticky handshake timeout flag (0 unless MIC_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module mic_sample_scheduler #(
  parameter int NUM_MICS       = 4,
  parameter int DATA_W         = 12,
  parameter int SAMPLE_DIV     = 2500,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [NUM_MICS-1:0]        i_mic_done,
  input  logic [NUM_MICS*DATA_W-1:0] i_mic_data,
  output logic [NUM_MICS-1:0]        o_mic_start,
  output logic [NUM_MICS*DATA_W-1:0] o_samples,
  output logic                       o_frame_valid,
  output logic [15:0]                o_frame_count,
  output logic                       o_overrun,
  output logic                       o_busy,
  output logic                       o_timeout_err
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_START     = 3'd2,
    S_CONVERT   = 3'd3,
    S_CAPTURE   = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [TICK_W-1:0]          r_tick_cnt;
  logic                       w_tick;

  logic [NUM_MICS-1:0]        r_acked;
  logic [NUM_MICS-1:0]        w_acked_next;
  logic [NUM_MICS-1:0]        w_start_next;
  logic                       w_all_acked;
  logic                       w_all_done;
  logic                       w_in_frame;
  logic                       w_phase_expired;

  logic [NUM_MICS-1:0]        r_mic_start;
  logic [NUM_MICS*DATA_W-1:0] r_samples;
  logic                       r_frame_valid;
  logic [15:0]                r_frame_count;
  logic                       r_overrun;

  // ---------------------------------------------------------------------------
  // Sample tick divider: runs only while enabled, so the first tick lands
  // exactly SAMPLE_DIV cycles after enable rises.
  // ---------------------------------------------------------------------------
  assign w_tick = i_enable && (r_tick_cnt == TICK_W'(SAMPLE_DIV - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick_cnt <= '0;
    end else if (!i_enable || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel acknowledge tracking. A channel counts as acknowledged once its
  // done level has been seen low during START. Its start request is then
  // withdrawn, so a fast channel that finishes and re-raises done while a slow
  // one is still acknowledging is not started a second time.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_MICS; gi++) begin : g_chan
      assign w_acked_next[gi] = (r_state == S_START) &&
                                (r_acked[gi] || !i_mic_done[gi]);
      assign w_start_next[gi] = (w_state_next == S_START) && !w_acked_next[gi];
    end
  endgenerate

  assign w_all_acked = &w_acked_next;
  assign w_all_done  = &i_mic_done;
  assign w_in_frame  = (r_state == S_START) || (r_state == S_CONVERT) ||
                       (r_state == S_CAPTURE);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_acked <= '0;
    end else begin
      r_acked <= w_acked_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional handshake watchdog
  // ---------------------------------------------------------------------------
`ifdef MIC_TIMEOUT_EN
  localparam int PH_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [PH_W-1:0] r_phase_cnt;
  logic            r_timeout_err;
  logic            w_abort;

  // Restarts from zero on every state change, so it measures time spent in
  // the current handshake phase only.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_phase_cnt <= '0;
    end else if ((r_state != w_state_next) ||
                 !((r_state == S_START) || (r_state == S_CONVERT))) begin
      r_phase_cnt <= '0;
    end else begin
      r_phase_cnt <= r_phase_cnt + PH_W'(1);
    end
  end

  assign w_phase_expired = ((r_state == S_START) || (r_state == S_CONVERT)) &&
                           (r_phase_cnt == PH_W'(TIMEOUT_CYCLES - 1));

  // Progress out of the phase takes priority, so an abort is only an
  // expiry that actually sends the FSM back to WAIT_TICK.
  assign w_abort = w_phase_expired && (w_state_next == S_WAIT_TICK);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_abort) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_phase_expired = 1'b0;
  assign o_timeout_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_enable) begin
          w_state_next = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (!i_enable) begin
          w_state_next = S_IDLE;
        end else if (w_tick) begin
          w_state_next = S_START;
        end
      end
      // Enable is deliberately ignored from here to CAPTURE: a frame that
      // has started is always completed and captured.
      S_START: begin
        if (w_all_acked) begin
          w_state_next = S_CONVERT;
        end else if (w_phase_expired) begin
          w_state_next = S_WAIT_TICK;
        end
      end
      S_CONVERT: begin
        if (w_all_done) begin
          w_state_next = S_CAPTURE;
        end else if (w_phase_expired) begin
          w_state_next = S_WAIT_TICK;
        end
      end
      S_CAPTURE: begin
        w_state_next = S_WAIT_TICK;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs. Data is latched at the end of the CAPTURE cycle and the
  // valid pulse is registered alongside it, so o_samples already holds the new
  // frame in the o_frame_valid cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_mic_start   <= '0;
      r_samples     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_mic_start   <= w_start_next;
      r_frame_valid <= (r_state == S_CAPTURE);
      if (r_state == S_CAPTURE) begin
        r_samples     <= i_mic_data;
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  // Ticks arriving mid-frame are dropped rather than queued; the flag records
  // that at least one sample period was lost since sampling was enabled.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_overrun <= 1'b0;
    end else if (!i_enable) begin
      r_overrun <= 1'b0;
    end else if (w_tick && w_in_frame) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_mic_start   = r_mic_start;
  assign o_samples     = r_samples;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_count = r_frame_count;
  assign o_overrun     = r_overrun;
  assign o_busy        = w_in_frame;

endmodule

// File: doc/mic_sample_scheduler.md
Name: mic_sample_scheduler

Overview:
Sample-rate controller for the tracking microphone array. Generates a fixed sample tick, starts all PmodMIC serial interfaces simultaneously so that channel samples are time-aligned for localization, and waits for every channel to complete. It then latches the 12-bit results into one frame and pulses frame_valid. It sits between the per-mic serial interface instances and the localization/correlation logic.

Parameters:
NUM_MICS, 4, number of microphone interface channels
DATA_W, 12, sample width per channel
SAMPLE_DIV, 2500, clock cycles per sample period (27 MHz -> 10.8 kHz)
TIMEOUT_CYCLES, 512, max cycles per handshake phase before abort (only used with MIC_TIMEOUT_EN)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
enable  input  1  sampling enable
mic_done  input  NUM_MICS  per-channel done level from mic interfaces (high = idle)
mic_data  input  NUM_MICS*DATA_W  per-channel result, channel i at [i*DATA_W +: DATA_W]
mic_start  output  NUM_MICS  per-channel start request
samples  output  NUM_MICS*DATA_W  latched frame, same packing as mic_data
frame_valid  output  1  one-cycle pulse when samples is updated
frame_count  output  16  number of frames captured
overrun  output  1  sticky: tick arrived while frame in progress
busy  output  1  high in any state other than IDLE and WAIT_TICK
timeout_err  output  1  sticky handshake timeout flag

Behaviour:
- Reset (reset=0, async): state=IDLE, tick counter=0, mic_start=0, samples=0, frame_valid=0, frame_count=0, overrun=0, busy=0, timeout_err=0.
- Tick counter: counts 0..SAMPLE_DIV-1 while enable=1, wraps to 0; tick is a one-cycle strobe at count SAMPLE_DIV-1. enable=0 holds the counter at 0. First tick occurs SAMPLE_DIV cycles after enable rises.
- States:
  IDLE: enable=1 -> WAIT_TICK.
  WAIT_TICK: enable=0 -> IDLE; tick -> START.
  START: mic_start all high; stay until mic_done == 0 on every channel (acknowledged; mic interfaces run on a divided clock, so start is held level rather than pulsed) -> CONVERT.
  CONVERT: mic_start=0; stay until mic_done all 1 -> CAPTURE.
  CAPTURE: samples <= mic_data, frame_valid=1 for this cycle, frame_count+1 (wraps 16'hFFFF->0) -> WAIT_TICK.
- Latency: tick to frame_valid = (start ack cycles) + (conversion cycles) + 1 register cycle; samples are stable from the frame_valid cycle until the next CAPTURE.
- Overrun: a tick while state is START, CONVERT or CAPTURE sets overrun and is dropped; no queued frame. overrun clears only on reset or enable=0.
- enable falls mid-frame: current frame completes and is captured; FSM then goes WAIT_TICK -> IDLE.
- Channels that ack/finish at different cycles: wait for the slowest; a channel that re-raises done early is not re-started.
- samples and frame_count are registered outputs; frame_valid never asserts for two consecutive cycles.

Optional Feature:
MIC_TIMEOUT_EN: when defined, a phase counter reset on entry to START and CONVERT aborts the frame if TIMEOUT_CYCLES elapse in either state: mic_start=0, timeout_err set (sticky until reset), no frame_valid, frame_count unchanged, return to WAIT_TICK. When undefined, no counter exists, FSM waits indefinitely, and timeout_err is tied 0.

Test Plan:
- Reset/idle: reset=0 then 1, enable=0 for 5000 cycles -> mic_start=0, frame_valid never pulses, all outputs 0.
- Nominal frame: SAMPLE_DIV=100, enable=1, model mics ack after 4 cycles and finish after 64, data ch0..3=12'h123,12'h456,12'h789,12'hABC -> frame_valid at about cycle 100+4+64+1, samples=48'hABC789456123, frame_count=1; 10 periods -> frame_count=10.
- Skewed channels: ch2 finishes 30 cycles after others -> single frame_valid after ch2 done, data from all four channels correct.
- Overrun: SAMPLE_DIV=50, mic conversion takes 80 cycles -> overrun=1 after the second tick, frames every other period, overrun clears after enable=0.
- Enable drop mid-frame: deassert enable during CONVERT -> that frame still captured (frame_valid=1), then no further mic_start.
- Timeout (MIC_TIMEOUT_EN, TIMEOUT_CYCLES=512): ch1 never drops done -> after 512 cycles in START mic_start=0, timeout_err=1, frame_count unchanged, next tick restarts; async reset mid-CONVERT -> immediate return to reset values.
